// File: rtl/count_bcd_display.sv
// 8-bit binary to 3-digit BCD converter (serial double-dabble, one bit per clock)
// driving a time-multiplexed 7-segment display with optional leading-zero blanking.
module count_bcd_display #(
  parameter int REFRESH_DIV = 1024,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [1:0] bcd_hun,
  output logic [3:0] bcd_ten,
  output logic [3:0] bcd_one,
  output logic [6:0] seg,
  output logic [2:0] dig_sel
);

  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_nxt;
  // {hundreds[1:0], tens[3:0], ones[3:0], binary[7:0]}
  logic [17:0] sr, sr_nxt, sr_dab;
  logic [2:0]  iter, iter_nxt;
  logic        done_nxt, latch;

  logic [RW-1:0] ref_cnt;
  logic [1:0]    dig_idx;
  logic [3:0]    cur;
  logic          blank;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Hundreds never reaches 5 for an 8-bit input, so it needs no correction.
  assign sr_dab = {sr[17:16], add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    iter_nxt  = iter;
    done_nxt  = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sr_nxt    = {10'd0, count_in};
          iter_nxt  = 3'd0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        sr_nxt   = {sr_dab[16:0], 1'b0};
        iter_nxt = iter + 3'd1;
        if (iter == 3'd7) begin
          done_nxt  = 1'b1;
          latch     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      iter    <= '0;
      done    <= 1'b0;
      bcd_hun <= '0;
      bcd_ten <= '0;
      bcd_one <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      iter  <= iter_nxt;
      done  <= done_nxt;
      if (latch) begin
        bcd_hun <= sr_nxt[17:16];
        bcd_ten <= sr_nxt[15:12];
        bcd_one <= sr_nxt[11:8];
      end
    end
  end

  assign busy = (state == CONV);

  // Display scan runs continuously, whatever the converter is doing.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ref_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  assign dig_sel = 3'b001 << dig_idx;

  always_comb begin
    cur   = bcd_one;
    blank = 1'b0;
    case (dig_idx)
      2'd1: begin
        cur   = bcd_ten;
        blank = BLANK_LZ && (bcd_hun == 2'd0) && (bcd_ten == 4'd0);
      end
      2'd2: begin
        cur   = {2'b00, bcd_hun};
        blank = BLANK_LZ && (bcd_hun == 2'd0);
      end
      default: ;
    endcase
    seg = blank ? 7'h00 : seg7(cur);
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: two instances (blanking on/off) share stimulus and
// are compared every cycle against an arithmetic model, plus literal spot checks.
module tb_count_bcd_display;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] count_in = '0;
  logic       load = 1'b0;

  logic       busy_a, done_a, busy_b, done_b;
  logic [1:0] hun_a, hun_b;
  logic [3:0] ten_a, one_a, ten_b, one_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] sel_a, sel_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_bcd_display #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst_n(rst), .count_in(count_in), .load(load),
    .busy(busy_a), .done(done_a), .bcd_hun(hun_a), .bcd_ten(ten_a), .bcd_one(one_a),
    .seg(seg_a), .dig_sel(sel_a));

  count_bcd_display #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst_n(rst), .count_in(count_in), .load(load),
    .busy(busy_b), .done(done_b), .bcd_hun(hun_b), .bcd_ten(ten_b), .bcd_one(one_b),
    .seg(seg_b), .dig_sel(sel_b));

  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: a conversion is 8 cycles of "busy", then the decimal digits of the
  // captured value appear together with a one-cycle done.
  int m_cyc = 0, m_left = 0, m_val = 0, m_h = 0, m_t = 0, m_o = 0;
  bit m_busy = 0, m_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_busy = 0; m_done = 0; m_h = 0; m_t = 0; m_o = 0;
    end else begin
      m_cyc++;
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
          m_h = m_val / 100; m_t = (m_val / 10) % 10; m_o = m_val % 10;
        end
      end else if (load) begin
        m_busy = 1; m_left = 8; m_val = int'(count_in);
      end
    end
  end

  function automatic logic [6:0] exp_seg(input bit blz, input int idx);
    if (idx == 2) return (blz && m_h == 0) ? 7'h00 : seg_tbl[m_h];
    if (idx == 1) return (blz && m_h == 0 && m_t == 0) ? 7'h00 : seg_tbl[m_t];
    return seg_tbl[m_o];
  endfunction

  always @(negedge clk) begin
    int idx;
    idx = (m_cyc / R) % 3;
    chk("busy_a", busy_a, m_busy);
    chk("busy_b", busy_b, m_busy);
    chk("done_a", done_a, m_done);
    chk("done_b", done_b, m_done);
    chk("bcd_a", {hun_a, ten_a, one_a}, {m_h[1:0], m_t[3:0], m_o[3:0]});
    chk("bcd_b", {hun_b, ten_b, one_b}, {m_h[1:0], m_t[3:0], m_o[3:0]});
    chk("dig_sel_a", sel_a, 3'b001 << idx);
    chk("dig_sel_b", sel_b, 3'b001 << idx);
    chk("seg_a", seg_a, exp_seg(1'b1, idx));
    chk("seg_b", seg_b, exp_seg(1'b0, idx));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    count_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done_a !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Scan every digit position once; ea/eb indexed by digit (0 = ones).
  task automatic chk_disp(input string nm, input logic [2:0][6:0] ea, input logic [2:0][6:0] eb);
    logic [2:0] seen;
    seen = '0;
    for (int i = 0; i < 3 * R + 1; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (sel_a == (3'b001 << d) && !seen[d]) begin
          seen[d] = 1'b1;
          chk({nm, "_seg_a"}, seg_a, ea[d]);
          chk({nm, "_seg_b"}, seg_b, eb[d]);
        end
      end
      tick();
    end
    chk({nm, "_digits_seen"}, seen, 3'b111);
  endtask

  initial begin
    int n, nd;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_bcd", {hun_a, ten_a, one_a}, 10'd0);
    chk("rst_dig_sel", sel_a, 3'b001);
    chk("rst_seg", seg_a, 7'h3F);
    rst = 1'b0;
    tick();

    // 255: busy 8 cycles, 2/5/5, scan 6D 6D 5B
    pulse_load(8'd255);
    chk("busy_after_load", busy_a, 1'b1);
    wait_done(n);
    chk("lat_255", n, 8);
    chk("bcd_255", {hun_a, ten_a, one_a}, {2'd2, 4'd5, 4'd5});
    chk_disp("disp_255", {7'h5B, 7'h6D, 7'h6D}, {7'h5B, 7'h6D, 7'h6D});

    // 7: blanking differs between the two instances
    pulse_load(8'd7);
    wait_done(n);
    chk("bcd_7", {hun_a, ten_a, one_a}, {2'd0, 4'd0, 4'd7});
    chk_disp("disp_7", {7'h00, 7'h00, 7'h07}, {7'h3F, 7'h3F, 7'h07});

    // 100 with a 42 load at edge 3 ignored
    pulse_load(8'd100);
    tick(); tick();
    count_in = 8'd42; load = 1'b1;
    tick();
    load = 1'b0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      if (done_a === 1'b1) begin
        nd++;
        chk("bcd_100", {hun_a, ten_a, one_a}, {2'd1, 4'd0, 4'd0});
      end
      tick();
    end
    chk("done_count_100", nd, 1);

    // 199 then 38 back-to-back via held load
    count_in = 8'd199; load = 1'b1;
    tick();
    wait_done(n);
    chk("lat_199", n, 8);
    chk("bcd_199", {hun_a, ten_a, one_a}, {2'd1, 4'd9, 4'd9});
    count_in = 8'd38;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) load = 1'b0;
    end while (done_a !== 1'b1 && n < 20);
    chk("gap_38", n, 9);
    chk("bcd_38", {hun_a, ten_a, one_a}, {2'd0, 4'd3, 4'd8});
    tick();

    // reset mid-conversion of 250
    pulse_load(8'd250);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_bcd", {hun_a, ten_a, one_a}, 10'd0);
    chk("abort_dig_sel", sel_a, 3'b001);
    chk("abort_seg", seg_a, 7'h3F);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_a === 1'b1) nd++;
      tick();
    end
    chk("abort_no_done", nd, 0);

    // exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      pulse_load(v[7:0]);
      wait_done(n);
      chk("sweep_lat", n, 8);
      chk("sweep_bcd", {hun_a, ten_a, one_a},
          {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/count_bcd_display.md
COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

Interface
REQ-001 Parameter REFRESH_DIV, default 1024: clk cycles per displayed digit; legal range >= 2.
REQ-002 Parameter BLANK_LZ, default 1: 1 = leading-zero blanking on, 0 = off.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset is asynchronous and active-high: rst_n = 1 resets the block immediately, regardless of clk.
REQ-005 count_in  input  8  unsigned binary value from the counter block (0-255).
REQ-006 load  input  1  request to convert count_in; sampled only in IDLE.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when new BCD results are valid.
REQ-009 bcd_hun  output  2  hundreds digit (0-2), registered.
REQ-010 bcd_ten  output  4  tens digit (0-9), registered.
REQ-011 bcd_one  output  4  ones digit (0-9), registered.
REQ-012 seg  output  7  active-high segments {g,f,e,d,c,b,a} for the selected digit.
REQ-013 dig_sel  output  3  one-hot active-high digit enable: bit0 = ones, bit1 = tens, bit2 = hundreds.

Function
REQ-014 Conversion FSM SHALL have two states, IDLE and CONV.
REQ-015 IDLE with load = 1 at an edge: capture count_in into the shift register, clear the BCD scratch and the iteration count, set busy = 1, and go to CONV.
REQ-016 CONV: one double-dabble iteration per cycle.
- Add 3 to each scratch BCD nibble >= 5.
- Then shift the scratch/binary register left by one.
REQ-017 On the 8th CONV edge:
- Latch the final scratch digits into bcd_hun/bcd_ten/bcd_one.
- Set done = 1 and busy = 0.
- Return to IDLE.
REQ-018 Latency: load sampled at edge 0 -> results and done visible after edge 8; done high for exactly one cycle.
REQ-019 load = 1 while busy = 1 SHALL be ignored; no queuing; the conversion in progress is unaffected.
REQ-020 load = 1 in the cycle where done = 1 SHALL be accepted (FSM already IDLE); back-to-back conversions therefore take 9 cycles each.
REQ-021 Changes on count_in after capture SHALL NOT affect the conversion in progress.
REQ-022 bcd_* outputs SHALL hold their previous values during CONV and change only at the done edge.
REQ-023 Refresh counter SHALL be free-running (independent of FSM state) and count 0..REFRESH_DIV-1.
- At wrap, the digit index advances ones -> tens -> hundreds -> ones.
REQ-024 seg SHALL decode the selected registered digit with these codes:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); blank = 00.
REQ-025 With BLANK_LZ = 1, leading digits SHALL be blanked (seg = 00) as follows:
- Hundreds: blanked when bcd_hun = 0.
- Tens: blanked when bcd_hun = 0 and bcd_ten = 0.
- Ones: never blanked.
REQ-026 dig_sel SHALL remain one-hot at all times, including during conversion.

Reset
REQ-027 While rst_n = 1, all of the following SHALL hold:
- FSM = IDLE, busy = 0, done = 0.
- bcd_hun = 0, bcd_ten = 0, bcd_one = 0.
- Refresh counter = 0, digit index = ones, so dig_sel = 001 and seg = 3F.
REQ-028 Reset asserted mid-conversion SHALL abort it with no done pulse; bcd_* = 0 afterwards.
REQ-029 After rst_n falls, the first load SHALL be accepted at the next clk edge.

Verification
REQ-030 count_in = 255, load pulse -> busy for 8 cycles, done after edge 8, bcd = 2/5/5; with REFRESH_DIV = 4, seg sequence 6D, 6D, 5B.
REQ-031 count_in = 7, BLANK_LZ = 1 -> bcd = 0/0/7; seg = 07 on ones, 00 on tens and hundreds; with BLANK_LZ = 0 -> 07, 3F, 3F.
REQ-032 Load 100; second load of 42 at edge 3 while busy -> second load ignored, result 1/0/0, one done pulse only.
REQ-033 Load 199 with load held high at the done cycle and count_in = 38 -> done for 199 (1/9/9), then done 9 cycles later for 38 (0/3/8).
REQ-034 Assert rst_n at edge 4 of a conversion of 250 -> busy = 0 immediately, no done, bcd = 0/0/0, dig_sel = 001, seg = 3F.
REQ-035 Exhaustive sweep of count_in 0-255 -> bcd digits match integer division, every conversion latency = 8 cycles.
